// File: rtl/rpn_eval.sv
// RPN evaluator: consumes single-digit operands and + - * / = over a STB/ACK char link,
// evaluates on a signed operand stack and emits the result as signed decimal ASCII plus LF.
module rpn_eval #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_STB,
  input  logic [7:0] IN_CHAR,
  output logic       IN_ACK,
  output logic       OUT_STB,
  output logic [7:0] OUT_CHAR,
  input  logic       OUT_ACK
);

  localparam int AW   = $clog2(DEPTH);
  localparam int NDIG = (W * 30103 + 99999) / 100000;
  localparam int DW   = $clog2(NDIG + 1);
  localparam int CW   = $clog2(W + 1);

  typedef enum logic [2:0] {IDLE, EXEC, DIV, CONV, EMIT} state_t;

  state_t          state;
  logic [AW:0]     count;
  logic            err;
  logic            div_conv;
  logic            emit_e;
  logic            emit_neg;
  logic [CW-1:0]   dv_cnt;
  logic [DW-1:0]   ndig;
  logic [DW-1:0]   dig_left;

  logic signed [W-1:0] stk [DEPTH];
  logic [7:0]          op_p0;
  logic [W-1:0]        dv_rem;
  logic [W-1:0]        dv_quo;
  logic [W-1:0]        dv_den;
  logic                dv_neg;
  logic [3:0]          digs [NDIG];

  function automatic logic signed [W-1:0] alu_wrap(input logic [7:0] op,
                                                   input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
    logic signed [W-1:0] r;
    case (op)
      8'h2B:   r = a + b;
      8'h2D:   r = a - b;
      default: r = a * b;
    endcase
    return r;
  endfunction

  // Magnitude as unsigned, so the most negative value maps to 2^(W-1) exactly.
  function automatic logic [W-1:0] mag_u(input logic signed [W-1:0] x);
    logic signed [W-1:0] n;
    n = -x;
    return x[W-1] ? W'(n) : W'(x);
  endfunction

  logic [AW-1:0]       top_idx, sec_idx;
  logic signed [W-1:0] top, sec;
  logic                accept, is_dig, full, two, push_ok, div_bad;
  logic [W:0]          rem_sh, rem_sub;
  logic                take;
  logic [W-1:0]        nxt_rem, nxt_quo;
  logic signed [W-1:0] q_signed;
  logic                div_last, div_load_op, conv_load, div_reload;
  logic [7:0]          next_char;

  assign top_idx = AW'(count - 1'b1);
  assign sec_idx = AW'(count - 2'd2);
  assign top     = stk[top_idx];
  assign sec     = stk[sec_idx];

  assign accept  = (state == IDLE) && IN_STB && !IN_ACK;
  assign is_dig  = (IN_CHAR >= 8'h30) && (IN_CHAR <= 8'h39);
  assign full    = (count == (AW+1)'(DEPTH));
  assign two     = (count >= (AW+1)'(2));
  assign push_ok = accept && is_dig && !err && !full;
  assign div_bad = !two || (top == '0);

  // One restoring-division step; shared by '/' and the binary-to-decimal conversion.
  assign rem_sh   = {dv_rem, dv_quo[W-1]};
  assign rem_sub  = rem_sh - {1'b0, dv_den};
  assign take     = !rem_sub[W];
  assign nxt_rem  = take ? rem_sub[W-1:0] : rem_sh[W-1:0];
  assign nxt_quo  = {dv_quo[W-2:0], take};
  assign q_signed = dv_neg ? -$signed(nxt_quo) : $signed(nxt_quo);

  assign div_last    = (state == DIV) && (dv_cnt == CW'(W));
  assign div_load_op = (state == DIV) && (dv_cnt == '0) && !div_bad;
  assign conv_load   = (state == CONV) && !err && (count == (AW+1)'(1));
  assign div_reload  = div_last && div_conv && (nxt_quo != '0);

  always_comb begin
    next_char = 8'h0A;
    if (emit_e)
      next_char = 8'h45;
    else if (emit_neg)
      next_char = 8'h2D;
    else if (dig_left != '0)
      next_char = {4'h3, digs[dig_left - 1'b1]};
  end

  // Datapath: stack, divider and digit buffer carry no reset.
  always_ff @(posedge CLK) begin
    if (accept)
      op_p0 <= IN_CHAR;
    if (push_ok)
      stk[count[AW-1:0]] <= $signed({{(W-4){1'b0}}, IN_CHAR[3:0]});
    if (state == EXEC && two)
      stk[sec_idx] <= alu_wrap(op_p0, sec, top);
    if (div_last && !div_conv)
      stk[sec_idx] <= q_signed;

    if (div_load_op) begin
      dv_rem <= '0;
      dv_quo <= mag_u(sec);
      dv_den <= mag_u(top);
      dv_neg <= sec[W-1] ^ top[W-1];
    end else if (conv_load) begin
      dv_rem <= '0;
      dv_quo <= mag_u(top);
      dv_den <= W'(10);
    end else if (div_reload) begin
      dv_rem <= '0;
      dv_quo <= nxt_quo;
    end else if (state == DIV && dv_cnt != '0) begin
      dv_rem <= nxt_rem;
      dv_quo <= nxt_quo;
    end

    if (div_last && div_conv)
      digs[ndig] <= nxt_rem[3:0];
  end

  // Control FSM and registered handshake outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      count    <= '0;
      err      <= 1'b0;
      div_conv <= 1'b0;
      emit_e   <= 1'b0;
      emit_neg <= 1'b0;
      dv_cnt   <= '0;
      ndig     <= '0;
      dig_left <= '0;
      IN_ACK   <= 1'b0;
      OUT_STB  <= 1'b0;
      OUT_CHAR <= 8'h00;
    end else begin
      IN_ACK <= accept;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_dig) begin
              if (!err) begin
                if (full) err <= 1'b1;
                else      count <= count + 1'b1;
              end
            end else if (IN_CHAR == 8'h3D) begin
              state <= CONV;
            end else if (!err && (IN_CHAR == 8'h2B || IN_CHAR == 8'h2D || IN_CHAR == 8'h2A)) begin
              state <= EXEC;
            end else if (!err && IN_CHAR == 8'h2F) begin
              state    <= DIV;
              dv_cnt   <= '0;
              div_conv <= 1'b0;
            end
          end
        end
        EXEC: begin
          if (two) count <= count - 1'b1;
          else     err   <= 1'b1;
          state <= IDLE;
        end
        DIV: begin
          if (dv_cnt == '0) begin
            if (div_bad) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              dv_cnt <= CW'(1);
            end
          end else if (dv_cnt == CW'(W)) begin
            if (div_conv) begin
              ndig <= ndig + 1'b1;
              if (nxt_quo == '0) begin
                dig_left <= ndig + 1'b1;
                state    <= EMIT;
              end else begin
                dv_cnt <= CW'(1);
              end
            end else begin
              count  <= count - 1'b1;
              dv_cnt <= '0;
              state  <= IDLE;
            end
          end else begin
            dv_cnt <= dv_cnt + 1'b1;
          end
        end
        CONV: begin
          if (conv_load) begin
            emit_e   <= 1'b0;
            emit_neg <= top[W-1];
            ndig     <= '0;
            dv_cnt   <= CW'(1);
            div_conv <= 1'b1;
            state    <= DIV;
          end else begin
            emit_e   <= 1'b1;
            emit_neg <= 1'b0;
            dig_left <= '0;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (!OUT_STB) begin
            OUT_STB  <= 1'b1;
            OUT_CHAR <= next_char;
          end else if (OUT_ACK) begin
            OUT_STB <= 1'b0;
            if (emit_e)
              emit_e <= 1'b0;
            else if (emit_neg)
              emit_neg <= 1'b0;
            else if (dig_left != '0)
              dig_left <= dig_left - 1'b1;
            else begin
              count    <= '0;
              err      <= 1'b0;
              div_conv <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_eval.sv
// Directed bench for rpn_eval: feeds RPN strings and compares the emitted ASCII result.
module tb_rpn_eval;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_STB;
  logic [7:0] IN_CHAR;
  logic       IN_ACK;
  logic       OUT_STB;
  logic [7:0] OUT_CHAR;
  logic       OUT_ACK;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  rpn_eval #(.W(16), .DEPTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .IN_STB(IN_STB), .IN_CHAR(IN_CHAR), .IN_ACK(IN_ACK),
    .OUT_STB(OUT_STB), .OUT_CHAR(OUT_CHAR), .OUT_ACK(OUT_ACK)
  );

  function automatic string vis(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++)
      if (s[i] == 8'h0A) r = {r, "<LF>"};
      else r = $sformatf("%s%c", r, s[i]);
    return r;
  endfunction

  task automatic send_char(input byte c);
    bit done = 0;
    IN_CHAR = c;
    IN_STB  = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge CLK); #1;
      if (IN_ACK) done = 1;
    end
    IN_STB = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL send_ack char=%c: IN_ACK=0 after 60 cycles, required 1", c);
    end
  endtask

  task automatic get_char(output byte c, output bit ok, output int waited);
    ok = 0; c = 0; waited = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (OUT_STB) ok = 1;
      else begin @(posedge CLK); #1; waited++; end
    end
    if (ok) begin
      c = OUT_CHAR;
      OUT_ACK = 1'b1;
      @(posedge CLK); #1;
      OUT_ACK = 1'b0;
    end else begin
      tests++; fails++;
      $display("FAIL out_stb_timeout: OUT_STB=0 after 300 cycles, required 1");
    end
  endtask

  task automatic run_expr(input string s, output string got, output int lat);
    byte c; bit ok; int w;
    got = ""; lat = 0;
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    for (int n = 0; n < 10; n++) begin
      get_char(c, ok, w);
      if (n == 0) lat = w;
      if (!ok) break;
      got = $sformatf("%s%c", got, c);
      if (c == 8'h0A) break;
    end
  endtask

  task automatic test_reset();
    bit acked = 0;
    RST = 1'b1; IN_STB = 1'b1; IN_CHAR = "3"; OUT_ACK = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      if (IN_ACK) acked = 1;
    end
    tests++; if (acked !== 1'b0) begin fails++; $display("FAIL reset_in_ack: saw %0b, required 0", acked); end
    tests++; if (OUT_STB !== 1'b0) begin fails++; $display("FAIL reset_out_stb: %0b, required 0", OUT_STB); end
    tests++; if (OUT_CHAR !== 8'h00) begin fails++; $display("FAIL reset_out_char: %h, required 00", OUT_CHAR); end
    IN_STB = 1'b0;
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_add();
    string got; int lat;
    run_expr("34+=", got, lat);
    tests++; if (got != "7\n") begin fails++; $display("FAIL add: got %s, required 7<LF>", vis(got)); end
    tests++; if (OUT_STB !== 1'b0) begin fails++; $display("FAIL add_stb_idle: %0b, required 0", OUT_STB); end
    run_expr("1=", got, lat);
    tests++; if (got != "1\n") begin fails++; $display("FAIL add_next_expr: got %s, required 1<LF>", vis(got)); end
    run_expr("(3 4)+=", got, lat);
    tests++; if (got != "7\n") begin fails++; $display("FAIL ignored_chars: got %s, required 7<LF>", vis(got)); end
  endtask

  task automatic test_sub_mul_div();
    string got; int lat;
    run_expr("92-5*=", got, lat);
    tests++; if (got != "35\n") begin fails++; $display("FAIL sub_mul: got %s, required 35<LF>", vis(got)); end
    run_expr("27-3/=", got, lat);
    tests++; if (got != "-1\n") begin fails++; $display("FAIL div_trunc: got %s, required -1<LF>", vis(got)); end
    run_expr("84/=", got, lat);
    tests++; if (got != "2\n") begin fails++; $display("FAIL div_pos: got %s, required 2<LF>", vis(got)); end
    run_expr("0=", got, lat);
    tests++; if (got != "0\n") begin fails++; $display("FAIL zero: got %s, required 0<LF>", vis(got)); end
  endtask

  task automatic test_wrap();
    string got; int lat;
    run_expr("99*9*9*9*=", got, lat);
    tests++; if (got != "-6487\n") begin fails++; $display("FAIL mul_wrap: got %s, required -6487<LF>", vis(got)); end
    run_expr("088*8*8*8*-01-/=", got, lat);
    tests++; if (got != "-32768\n") begin fails++; $display("FAIL min_div: got %s, required -32768<LF>", vis(got)); end
    tests++; if (lat > 108) begin fails++; $display("FAIL conv_latency: %0d cycles, required <= 108", lat); end
  endtask

  task automatic test_errors();
    string got; int lat;
    run_expr("50/=", got, lat);
    tests++; if (got != "E\n") begin fails++; $display("FAIL div_zero: got %s, required E<LF>", vis(got)); end
    run_expr("+=", got, lat);
    tests++; if (got != "E\n") begin fails++; $display("FAIL underflow: got %s, required E<LF>", vis(got)); end
    run_expr("999999999=", got, lat);
    tests++; if (got != "E\n") begin fails++; $display("FAIL overflow: got %s, required E<LF>", vis(got)); end
    run_expr("+5=", got, lat);
    tests++; if (got != "E\n") begin fails++; $display("FAIL sticky_err: got %s, required E<LF>", vis(got)); end
    run_expr("12=", got, lat);
    tests++; if (got != "E\n") begin fails++; $display("FAIL count_not_one: got %s, required E<LF>", vis(got)); end
    run_expr("2=", got, lat);
    tests++; if (got != "2\n") begin fails++; $display("FAIL err_cleared: got %s, required 2<LF>", vis(got)); end
  endtask

  task automatic test_backpressure();
    string got; int lat; byte c; bit ok; int w;
    bit stb_drop = 0, chr_chg = 0, in_acked = 0;
    send_char("1");
    @(posedge CLK); #1;
    tests++; if (IN_ACK !== 1'b0) begin fails++; $display("FAIL ack_pulse_width: IN_ACK=%0b, required 0", IN_ACK); end
    send_char("2");
    send_char("+");
    send_char("=");
    for (int i = 0; i < 300 && !OUT_STB; i++) begin @(posedge CLK); #1; end
    tests++; if (OUT_CHAR !== "3" || OUT_STB !== 1'b1) begin
      fails++; $display("FAIL bp_first: stb=%0b char=%h, required stb=1 char=33", OUT_STB, OUT_CHAR);
    end
    IN_CHAR = "5"; IN_STB = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      if (OUT_STB !== 1'b1) stb_drop = 1;
      if (OUT_CHAR !== "3") chr_chg = 1;
      if (IN_ACK) in_acked = 1;
    end
    IN_STB = 1'b0;
    tests++; if (stb_drop) begin fails++; $display("FAIL bp_stb_held: OUT_STB dropped, required held 1"); end
    tests++; if (chr_chg) begin fails++; $display("FAIL bp_char_stable: OUT_CHAR changed, required 33"); end
    tests++; if (in_acked) begin fails++; $display("FAIL bp_no_in_ack: IN_ACK=1 during EMIT, required 0"); end
    get_char(c, ok, w);
    get_char(c, ok, w);
    tests++; if (c !== 8'h0A) begin fails++; $display("FAIL bp_lf: %h, required 0a", c); end
    run_expr("4=", got, lat);
    tests++; if (got != "4\n") begin fails++; $display("FAIL bp_after: got %s, required 4<LF>", vis(got)); end
  endtask

  task automatic test_rst_during_div();
    string got; int lat;
    send_char("8");
    send_char("4");
    send_char("/");
    RST = 1'b1;
    #1;
    tests++; if (IN_ACK !== 1'b0 || OUT_STB !== 1'b0 || OUT_CHAR !== 8'h00) begin
      fails++; $display("FAIL rst_div_outputs: ack=%0b stb=%0b char=%h, required 0 0 00", IN_ACK, OUT_STB, OUT_CHAR);
    end
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK); #1;
    tests++; if (OUT_STB !== 1'b0) begin fails++; $display("FAIL rst_div_no_out: OUT_STB=%0b, required 0", OUT_STB); end
    run_expr("5=", got, lat);
    tests++; if (got != "5\n") begin fails++; $display("FAIL rst_div_after: got %s, required 5<LF>", vis(got)); end
  endtask

  initial begin
    RST = 1'b1; IN_STB = 1'b0; IN_CHAR = 8'h00; OUT_ACK = 1'b0;
    @(posedge CLK); #1;
    test_reset();
    test_add();
    test_sub_mul_div();
    test_wrap();
    test_errors();
    test_backpressure();
    test_rst_during_div();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
